// File: rtl/cpu6_dmem_responder_if.sv
// Purpose: request/response bundle between a cpu6 data-memory requester and its responder.
// Latency: none, wires only.
// Backpressure: valid/ready on both channels; master drives req_* and rsp_ready, slave drives req_ready and rsp_*.
// Signals: req_valid/req_ready/req_we/req_addr/req_wdata/req_wstrb, rsp_valid/rsp_ready/rsp_rdata/rsp_err.
interface cpu6_dmem_responder_if #(
  parameter int XLEN = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [XLEN-1:0]   req_addr;
  logic [XLEN-1:0]   req_wdata;
  logic [XLEN/8-1:0] req_wstrb;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [XLEN-1:0]   rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_wstrb, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_wstrb, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/cpu6_dmem_responder.sv
// Purpose: word-addressed SRAM model answering cpu6 data-memory loads/stores with byte strobes.
// Latency: rsp_valid rises WAIT_CYCLES+1 cycles after the accepting cycle; one request outstanding.
// Backpressure: req_ready only in IDLE; response held stable until rsp_ready.
// Ports: clk, reset (async, active-low), bus (slave modport: req_* in, req_ready out, rsp_* out, rsp_ready in).
module cpu6_dmem_responder #(
  parameter int XLEN        = 32,
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  cpu6_dmem_responder_if.slave  bus
);
  localparam int          STRB      = XLEN / 8;
  localparam int          LANE_LSB  = $clog2(STRB);
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t            state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic              enter_resp;
  logic              accept;

  logic              lat_we;
  logic [XLEN-1:0]   lat_addr;
  logic [XLEN-1:0]   lat_wdata;
  logic [STRB-1:0]   lat_wstrb;

  logic              eff_we;
  logic [XLEN-1:0]   eff_addr;
  logic [XLEN-1:0]   eff_wdata;
  logic [STRB-1:0]   eff_wstrb;
  logic [DEPTH_LOG2-1:0] eff_idx;
  logic              eff_err;

  logic [XLEN-1:0]   rdata_q;
  logic              err_q;

  logic [XLEN-1:0]   mem [0:(1<<DEPTH_LOG2)-1];

  assign accept        = (state == S_IDLE) && bus.req_valid;
  assign bus.req_ready = (state == S_IDLE);
  assign bus.rsp_valid = (state == S_RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

  // With zero wait states the response is formed on the accepting edge, so
  // the live request must be used instead of the (not yet loaded) latches.
  always_comb begin
    eff_we    = lat_we;
    eff_addr  = lat_addr;
    eff_wdata = lat_wdata;
    eff_wstrb = lat_wstrb;
    if (state == S_IDLE) begin
      eff_we    = bus.req_we;
      eff_addr  = bus.req_addr;
      eff_wdata = bus.req_wdata;
      eff_wstrb = bus.req_wstrb;
    end
  end

  assign eff_idx = eff_addr[DEPTH_LOG2+LANE_LSB-1:LANE_LSB];
  assign eff_err = (eff_addr[LANE_LSB-1:0] != '0) ||
                   (eff_addr[XLEN-1:DEPTH_LOG2+LANE_LSB] != '0);

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    enter_resp = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (WAIT_CYCLES > 0) begin
            state_nxt = S_WAIT;
            cnt_nxt   = WAIT_INIT;
          end else begin
            state_nxt  = S_RESP;
            enter_resp = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (cnt == 4'd1) begin
          state_nxt  = S_RESP;
          cnt_nxt    = 4'd0;
          enter_resp = 1'b1;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // The array shares this block so that nothing commits while reset is low;
  // the reset branch deliberately leaves the array contents untouched.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_wstrb <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        lat_we    <= bus.req_we;
        lat_addr  <= bus.req_addr;
        lat_wdata <= bus.req_wdata;
        lat_wstrb <= bus.req_wstrb;
      end
      if (enter_resp) begin
        err_q   <= eff_err;
        rdata_q <= (eff_err || eff_we) ? '0 : mem[eff_idx];
        if (eff_we && !eff_err) begin
          for (int i = 0; i < STRB; i++) begin
            if (eff_wstrb[i]) mem[eff_idx][8*i +: 8] <= eff_wdata[8*i +: 8];
          end
        end
      end else if ((state == S_RESP) && bus.rsp_ready) begin
        rdata_q <= '0;
        err_q   <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_cpu6_dmem_responder.sv
// Purpose: directed bench for cpu6_dmem_responder, a 2-wait-state and a 0-wait-state instance.
// Latency: inputs driven and outputs sampled on the falling clock edge.
// Backpressure: rsp_ready held low for several cycles to check response hold and request blocking.
module tb_cpu6_dmem_responder;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  cpu6_dmem_responder_if #(.XLEN(32)) bus_w2 ();
  cpu6_dmem_responder_if #(.XLEN(32)) bus_w0 ();

  cpu6_dmem_responder #(.XLEN(32), .DEPTH_LOG2(10), .WAIT_CYCLES(2)) u_dut_w2 (
    .clk(clk), .reset(reset), .bus(bus_w2.slave)
  );
  cpu6_dmem_responder #(.XLEN(32), .DEPTH_LOG2(10), .WAIT_CYCLES(0)) u_dut_w0 (
    .clk(clk), .reset(reset), .bus(bus_w0.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One complete transaction on the 2-wait-state instance; called on a falling edge.
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, output int lat, output logic [31:0] rdata,
                        output logic err);
    int n;
    bus_w2.req_valid = 1'b1;
    bus_w2.req_we    = we;
    bus_w2.req_addr  = addr;
    bus_w2.req_wdata = wdata;
    bus_w2.req_wstrb = strb;
    bus_w2.rsp_ready = 1'b1;
    n = 0;
    while (!bus_w2.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus_w2.req_ready) check("req_ready_timeout", 32'(bus_w2.req_ready), 32'd1);
    @(negedge clk);
    bus_w2.req_valid = 1'b0;
    lat = 1;
    while (!bus_w2.rsp_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    rdata = bus_w2.rsp_rdata;
    err   = bus_w2.rsp_err;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    logic [31:0] rd;
    logic        er;

    bus_w2.req_valid = 1'b0; bus_w2.req_we = 1'b0; bus_w2.req_addr = '0;
    bus_w2.req_wdata = '0;   bus_w2.req_wstrb = '0; bus_w2.rsp_ready = 1'b1;
    bus_w0.req_valid = 1'b0; bus_w0.req_we = 1'b0; bus_w0.req_addr = '0;
    bus_w0.req_wdata = '0;   bus_w0.req_wstrb = '0; bus_w0.rsp_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_rsp_valid", 32'(bus_w2.rsp_valid), 32'd0);
    check("rst_req_ready", 32'(bus_w2.req_ready), 32'd1);
    check("rst_rsp_rdata", bus_w2.rsp_rdata, 32'd0);
    check("rst_rsp_err",   32'(bus_w2.rsp_err), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Store then load with latency
    do_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, lat, rd, er);
    check("st_lat", 32'(lat), 32'd3);
    check("st_err", 32'(er), 32'd0);
    check("st_rdata", rd, 32'd0);
    do_req(1'b0, 32'h10, 32'h0, 4'h0, lat, rd, er);
    check("ld_lat", 32'(lat), 32'd3);
    check("ld_rdata", rd, 32'hDEADBEEF);
    check("ld_err", 32'(er), 32'd0);

    // Byte strobes, then an all-zero strobe store
    do_req(1'b1, 32'h10, 32'h11223344, 4'b0101, lat, rd, er);
    do_req(1'b0, 32'h10, 32'h0, 4'h0, lat, rd, er);
    check("strb_rdata", rd, 32'hDE22BE44);
    do_req(1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, lat, rd, er);
    check("strb0_err", 32'(er), 32'd0);
    do_req(1'b0, 32'h10, 32'h0, 4'h0, lat, rd, er);
    check("strb0_rdata", rd, 32'hDE22BE44);

    // Top word of the array is in range
    do_req(1'b1, 32'hFFC, 32'h12345678, 4'hF, lat, rd, er);
    check("top_st_err", 32'(er), 32'd0);
    do_req(1'b0, 32'hFFC, 32'h0, 4'h0, lat, rd, er);
    check("top_ld_rdata", rd, 32'h12345678);

    // Errors: misaligned load, out-of-range store aliasing word 0, misaligned store
    do_req(1'b1, 32'h0, 32'hCAFEF00D, 4'hF, lat, rd, er);
    do_req(1'b0, 32'h13, 32'h0, 4'h0, lat, rd, er);
    check("mis_ld_err", 32'(er), 32'd1);
    check("mis_ld_rdata", rd, 32'd0);
    do_req(1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF, lat, rd, er);
    check("oor_st_err", 32'(er), 32'd1);
    check("oor_st_lat", 32'(lat), 32'd3);
    do_req(1'b1, 32'h12, 32'hFFFFFFFF, 4'hF, lat, rd, er);
    check("mis_st_err", 32'(er), 32'd1);
    do_req(1'b0, 32'h0, 32'h0, 4'h0, lat, rd, er);
    check("oor_word0_kept", rd, 32'hCAFEF00D);
    do_req(1'b0, 32'h10, 32'h0, 4'h0, lat, rd, er);
    check("mis_word4_kept", rd, 32'hDE22BE44);

    // Backpressure with a second request waiting; its fields change during WAIT
    bus_w2.rsp_ready = 1'b0;
    bus_w2.req_valid = 1'b1; bus_w2.req_we = 1'b0; bus_w2.req_addr = 32'h10;
    @(negedge clk);
    bus_w2.req_addr = 32'h0;
    lat = 1;
    while (!bus_w2.rsp_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check("bp_lat", 32'(lat), 32'd3);
    for (int i = 0; i < 5; i++) begin
      check("bp_rsp_valid", 32'(bus_w2.rsp_valid), 32'd1);
      check("bp_rdata", bus_w2.rsp_rdata, 32'hDE22BE44);
      check("bp_req_ready", 32'(bus_w2.req_ready), 32'd0);
      @(negedge clk);
    end
    bus_w2.rsp_ready = 1'b1;
    @(negedge clk);
    check("hs_rsp_valid", 32'(bus_w2.rsp_valid), 32'd0);
    check("hs_rdata", bus_w2.rsp_rdata, 32'd0);
    check("hs_req_ready", 32'(bus_w2.req_ready), 32'd1);
    @(negedge clk);
    bus_w2.req_valid = 1'b0;
    lat = 1;
    while (!bus_w2.rsp_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check("bp2_lat", 32'(lat), 32'd3);
    check("bp2_rdata", bus_w2.rsp_rdata, 32'hCAFEF00D);
    @(negedge clk);

    // Reset during WAIT drops an uncommitted store; committed data persists
    do_req(1'b1, 32'h20, 32'hA5A5A5A5, 4'hF, lat, rd, er);
    bus_w2.req_valid = 1'b1; bus_w2.req_we = 1'b1; bus_w2.req_addr = 32'h20;
    bus_w2.req_wdata = 32'h55; bus_w2.req_wstrb = 4'hF;
    @(negedge clk);
    bus_w2.req_valid = 1'b0;
    check("mid_in_wait", 32'(bus_w2.req_ready), 32'd0);
    reset = 1'b0;
    #1;
    check("mid_rst_rsp_valid", 32'(bus_w2.rsp_valid), 32'd0);
    check("mid_rst_req_ready", 32'(bus_w2.req_ready), 32'd1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    do_req(1'b0, 32'h20, 32'h0, 4'h0, lat, rd, er);
    check("mid_rst_dropped", rd, 32'hA5A5A5A5);
    do_req(1'b0, 32'h10, 32'h0, 4'h0, lat, rd, er);
    check("mid_rst_persist", rd, 32'hDE22BE44);

    // Zero wait states: store, then back-to-back loads every second cycle
    bus_w0.rsp_ready = 1'b1;
    bus_w0.req_valid = 1'b1; bus_w0.req_we = 1'b1; bus_w0.req_addr = 32'h8;
    bus_w0.req_wdata = 32'h0BADC0DE; bus_w0.req_wstrb = 4'hF;
    @(negedge clk);
    check("w0_st_valid", 32'(bus_w0.rsp_valid), 32'd1);
    check("w0_st_err", 32'(bus_w0.rsp_err), 32'd0);
    bus_w0.req_we = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("w0_gap_valid", 32'(bus_w0.rsp_valid), 32'd0);
      check("w0_gap_ready", 32'(bus_w0.req_ready), 32'd1);
      @(negedge clk);
      check("w0_ld_valid", 32'(bus_w0.rsp_valid), 32'd1);
      check("w0_ld_rdata", bus_w0.rsp_rdata, 32'h0BADC0DE);
    end
    bus_w0.req_valid = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
